// File: rtl/y_run_ctl_pkg.sv
// ---------------------------------------------------------------------------
// y_run_ctl_pkg
// Shared definitions for the run/debug sequencer of the single-cycle CPU:
//   - run_state_e  : sequencer state encodings
//   - stop_cause_e : stop cause codes reported on the cause output
//   - HALT_INS_DEFAULT / CNT_W_DEFAULT : default parameter values
// ---------------------------------------------------------------------------
package y_run_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_STOPPED = 3'd4
  } run_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_EXT    = 3'd1,
    CAUSE_HALT   = 3'd2,
    CAUSE_BP     = 3'd3,
    CAUSE_BUDGET = 3'd4
  } stop_cause_e;

  localparam logic [31:0] HALT_INS_DEFAULT = 32'h0000_000C;
  localparam int          CNT_W_DEFAULT    = 32;

endpackage

// File: rtl/y_run_ctl_if.sv
// ---------------------------------------------------------------------------
// y_run_ctl_if
// Control/status bundle between the CPU test harness (master) and the
// run/debug sequencer (slave).
//   master drives : start, resume, step, halt_req, entry_point, max_cycles,
//                   bp_en, bp_addr, pc, ins
//   slave drives  : pc_load, pc_entry, cpu_en, busy, done, cause, ins_count
// ---------------------------------------------------------------------------
interface y_run_ctl_if #(
  parameter int CNT_W = 32
);

  logic             start;
  logic             resume;
  logic             step;
  logic             halt_req;
  logic [31:0]      entry_point;
  logic [CNT_W-1:0] max_cycles;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic [31:0]      ins;

  logic             pc_load;
  logic [31:0]      pc_entry;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic [2:0]       cause;
  logic [CNT_W-1:0] ins_count;

  modport master (
    output start, resume, step, halt_req, entry_point, max_cycles,
           bp_en, bp_addr, pc, ins,
    input  pc_load, pc_entry, cpu_en, busy, done, cause, ins_count
  );

  modport slave (
    input  start, resume, step, halt_req, entry_point, max_cycles,
           bp_en, bp_addr, pc, ins,
    output pc_load, pc_entry, cpu_en, busy, done, cause, ins_count
  );

endinterface

// File: rtl/y_run_ctl_stop_chk.sv
// ---------------------------------------------------------------------------
// y_stop_chk
// Purely combinational stop-condition priority checker, evaluated on the
// instruction about to execute. Priority: external request, halt
// instruction, breakpoint (unless skipped), instruction budget.
// Ports:
//   halt_req, ins, pc, bp_en, bp_addr, bp_skip, budget_en,
//   ins_count, max_cycles  : inputs
//   hit   : some stop condition is true this cycle
//   cause : highest-priority stop cause (CAUSE_NONE when no hit)
// ---------------------------------------------------------------------------
module y_stop_chk
  import y_run_ctl_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEFAULT,
  parameter logic [31:0] HALT_INS = HALT_INS_DEFAULT
) (
  input  logic             halt_req,
  input  logic [31:0]      ins,
  input  logic [31:0]      pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic             bp_skip,
  input  logic             budget_en,
  input  logic [CNT_W-1:0] ins_count,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             hit,
  output stop_cause_e      cause
);

  // Priority-encode the stop conditions; a zero budget means unlimited.
  always_comb begin
    hit   = 1'b0;
    cause = CAUSE_NONE;
    if (halt_req) begin
      hit   = 1'b1;
      cause = CAUSE_EXT;
    end else if (ins == HALT_INS) begin
      hit   = 1'b1;
      cause = CAUSE_HALT;
    end else if (bp_en && (pc == bp_addr) && !bp_skip) begin
      hit   = 1'b1;
      cause = CAUSE_BP;
    end else if (budget_en && (max_cycles != {CNT_W{1'b0}}) &&
                 (ins_count == max_cycles)) begin
      hit   = 1'b1;
      cause = CAUSE_BUDGET;
    end else begin
      hit   = 1'b0;
      cause = CAUSE_NONE;
    end
  end

endmodule

// File: rtl/y_run_ctl.sv
// ---------------------------------------------------------------------------
// y_run_ctl
// Run/debug sequencer for the single-cycle CPU datapath. Loads the entry
// point into the PC, then gates datapath state updates with cpu_en while
// running free or single-stepping, and stops on an external request, a
// halt instruction, a PC breakpoint or an instruction budget.
// Ports:
//   clk : rising-edge clock
//   INT : asynchronous active-high reset
//   bus : y_run_ctl_if.slave control/status bundle
// All outputs are registered except cpu_en, which is combinational from
// state, pc and ins so it is valid in the cycle the instruction executes.
// ---------------------------------------------------------------------------
module y_run_ctl
  import y_run_ctl_pkg::*;
#(
  parameter logic [31:0] HALT_INS = HALT_INS_DEFAULT,
  parameter int          CNT_W    = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        INT,
  y_run_ctl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  run_state_e       state_r;
  logic             pc_load_r;
  logic [31:0]      pc_entry_r;
  logic             busy_r;
  logic             done_r;
  stop_cause_e      cause_r;
  logic [CNT_W-1:0] ins_count_r;
  // Suppresses the breakpoint on the first instruction after resuming
  // from a breakpoint stop, so the same PC does not stop again.
  logic             bp_skip_r;

  logic             budget_en_s;
  logic             hit_s;
  stop_cause_e      hit_cause_s;
  logic             cpu_en_s;

  // Budget is only enforced in free-run; single steps ignore it.
  assign budget_en_s = (state_r == ST_RUN);

  y_stop_chk #(
    .CNT_W    (CNT_W),
    .HALT_INS (HALT_INS)
  ) u_stop_chk (
    .halt_req   (bus.halt_req),
    .ins        (bus.ins),
    .pc         (bus.pc),
    .bp_en      (bus.bp_en),
    .bp_addr    (bus.bp_addr),
    .bp_skip    (bp_skip_r),
    .budget_en  (budget_en_s),
    .ins_count  (ins_count_r),
    .max_cycles (bus.max_cycles),
    .hit        (hit_s),
    .cause      (hit_cause_s)
  );

  // Datapath write enable: execute only in RUN/STEP when nothing stops us.
  always_comb begin
    cpu_en_s = 1'b0;
    if (((state_r == ST_RUN) || (state_r == ST_STEP)) && !hit_s) begin
      cpu_en_s = 1'b1;
    end else begin
      cpu_en_s = 1'b0;
    end
  end

  // Sequencer FSM; registered outputs are updated with the state they reflect.
  always_ff @(posedge clk or posedge INT) begin
    if (INT) begin
      state_r     <= ST_IDLE;
      pc_load_r   <= 1'b0;
      pc_entry_r  <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cause_r     <= CAUSE_NONE;
      ins_count_r <= CNT_ZERO;
      bp_skip_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_LOAD;
            pc_entry_r  <= bus.entry_point;
            pc_load_r   <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            cause_r     <= CAUSE_NONE;
            ins_count_r <= CNT_ZERO;
            bp_skip_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          state_r     <= ST_RUN;
          pc_load_r   <= 1'b0;
          busy_r      <= 1'b1;
          ins_count_r <= CNT_ZERO;
          cause_r     <= CAUSE_NONE;
        end

        ST_RUN: begin
          if (hit_s) begin
            state_r <= ST_STOPPED;
            cause_r <= hit_cause_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            // Counter wraps silently at 2^CNT_W.
            ins_count_r <= ins_count_r + CNT_ONE;
            bp_skip_r   <= 1'b0;
          end
        end

        ST_STEP: begin
          state_r <= ST_STOPPED;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          if (hit_s) begin
            cause_r <= hit_cause_s;
          end else begin
            cause_r     <= CAUSE_NONE;
            ins_count_r <= ins_count_r + CNT_ONE;
            bp_skip_r   <= 1'b0;
          end
        end

        ST_STOPPED: begin
          // Precedence: start, then resume, then step; halt_req is ignored.
          if (bus.start) begin
            state_r     <= ST_LOAD;
            pc_entry_r  <= bus.entry_point;
            pc_load_r   <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            cause_r     <= CAUSE_NONE;
            ins_count_r <= CNT_ZERO;
            bp_skip_r   <= 1'b0;
          end else if (bus.resume) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            cause_r   <= CAUSE_NONE;
            bp_skip_r <= (cause_r == CAUSE_BP);
          end else if (bus.step) begin
            state_r   <= ST_STEP;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            bp_skip_r <= (cause_r == CAUSE_BP);
          end else begin
            state_r <= ST_STOPPED;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          pc_load_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          cause_r   <= CAUSE_NONE;
          bp_skip_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_load   = pc_load_r;
  assign bus.pc_entry  = pc_entry_r;
  assign bus.cpu_en    = cpu_en_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cause     = cause_r;
  assign bus.ins_count = ins_count_r;

endmodule

// File: tb/tb_y_run_ctl.sv
// ---------------------------------------------------------------------------
// tb_y_run_ctl
// Directed bench for y_run_ctl. A tiny PC model stands in for yIF/yPC:
// it loads pc_entry when pc_load is high and advances by 4 when cpu_en is
// high; instruction memory returns HALT at halt_addr and a NOP elsewhere.
// ---------------------------------------------------------------------------
module tb_y_run_ctl;

  localparam logic [31:0] HALT = 32'h0000_000C;
  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] FAR  = 32'hFFFF_FFF0;

  logic clk;
  logic INT;
  int   n_vec;
  int   n_err;
  logic ce_last;
  logic [31:0] halt_addr;

  y_run_ctl_if #(.CNT_W(32)) bus ();

  y_run_ctl #(.HALT_INS(HALT), .CNT_W(32)) u_dut (
    .clk (clk),
    .INT (INT),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] fetch(input logic [31:0] a);
    return (a == halt_addr) ? HALT : NOP;
  endfunction

  // One clock: sample enables mid-cycle, then update the PC model after the edge.
  task automatic tick();
    logic le;
    logic ce;
    @(negedge clk);
    le = bus.pc_load;
    ce = bus.cpu_en;
    ce_last = ce;
    @(posedge clk);
    #1;
    if (le) bus.pc = bus.pc_entry;
    else if (ce) bus.pc = bus.pc + 32'd4;
    bus.ins = fetch(bus.pc);
  endtask

  task automatic run_until_done(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (bus.done) break;
      tick();
    end
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL run_until_done: got done=%0b, required 1 within %0d", bus.done, bound);
    end
  endtask

  task automatic launch(input logic [31:0] ep);
    bus.entry_point = ep;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_vec++; if (bus.pc_load !== 1'b0) begin n_err++; $display("FAIL rst_pc_load: got %0b required 0", bus.pc_load); end
    n_vec++; if (bus.cpu_en !== 1'b0) begin n_err++; $display("FAIL rst_cpu_en: got %0b required 0", bus.cpu_en); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b required 0", bus.done); end
    n_vec++; if (bus.cause !== 3'd0) begin n_err++; $display("FAIL rst_cause: got %0d required 0", bus.cause); end
    n_vec++; if (bus.ins_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d required 0", bus.ins_count); end
    n_vec++; if (bus.pc_entry !== 32'd0) begin n_err++; $display("FAIL rst_pc_entry: got %0d required 0", bus.pc_entry); end
  endtask

  task automatic test_start_count();
    bus.entry_point = 32'd128;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.pc_load !== 1'b1) begin n_err++; $display("FAIL load_pc_load: got %0b required 1", bus.pc_load); end
    n_vec++; if (bus.pc_entry !== 32'd128) begin n_err++; $display("FAIL load_pc_entry: got %0d required 128", bus.pc_entry); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %0b required 1", bus.busy); end
    n_vec++; if (bus.cpu_en !== 1'b0) begin n_err++; $display("FAIL load_cpu_en: got %0b required 0", bus.cpu_en); end
    tick();
    n_vec++; if (bus.pc_load !== 1'b0) begin n_err++; $display("FAIL run_pc_load: got %0b required 0", bus.pc_load); end
    n_vec++; if (bus.pc !== 32'd128) begin n_err++; $display("FAIL run_pc: got %0d required 128", bus.pc); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++; if (bus.ins_count !== 32'(k)) begin n_err++; $display("FAIL count_%0d: got %0d required %0d", k, bus.ins_count, k); end
      n_vec++; if (ce_last !== 1'b1) begin n_err++; $display("FAIL count_en_%0d: got %0b required 1", k, ce_last); end
    end
    // start together with halt_req while running: stop with cause 1, no restart
    bus.halt_req = 1'b1;
    bus.start = 1'b1;
    bus.entry_point = 32'd512;
    tick();
    bus.halt_req = 1'b0;
    bus.start = 1'b0;
    n_vec++; if (ce_last !== 1'b0) begin n_err++; $display("FAIL ext_en: got %0b required 0", ce_last); end
    n_vec++; if (bus.cause !== 3'd1) begin n_err++; $display("FAIL ext_cause: got %0d required 1", bus.cause); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ext_done: got %0b required 1", bus.done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ext_busy: got %0b required 0", bus.busy); end
    n_vec++; if (bus.pc_load !== 1'b0) begin n_err++; $display("FAIL ext_no_restart: got %0b required 0", bus.pc_load); end
    n_vec++; if (bus.ins_count !== 32'd3) begin n_err++; $display("FAIL ext_count: got %0d required 3", bus.ins_count); end
  endtask

  task automatic test_budget();
    int bad;
    bad = 0;
    bus.max_cycles = 32'd43;
    launch(32'd128);
    for (int k = 0; k < 43; k++) begin
      tick();
      n_vec++; if (ce_last !== 1'b1) begin n_err++; bad++; if (bad < 4) $display("FAIL budget_en_%0d: got %0b required 1", k, ce_last); end
    end
    tick();
    n_vec++; if (ce_last !== 1'b0) begin n_err++; $display("FAIL budget_44th_en: got %0b required 0", ce_last); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL budget_done: got %0b required 1", bus.done); end
    n_vec++; if (bus.cause !== 3'd4) begin n_err++; $display("FAIL budget_cause: got %0d required 4", bus.cause); end
    n_vec++; if (bus.ins_count !== 32'd43) begin n_err++; $display("FAIL budget_count: got %0d required 43", bus.ins_count); end
    n_vec++; if (bus.cpu_en !== 1'b0) begin n_err++; $display("FAIL budget_stopped_en: got %0b required 0", bus.cpu_en); end
    bus.max_cycles = 32'd0;
  endtask

  task automatic test_halt_ins();
    halt_addr = 32'd140;
    launch(32'd128);
    run_until_done(20);
    n_vec++; if (ce_last !== 1'b0) begin n_err++; $display("FAIL halt_en: got %0b required 0", ce_last); end
    n_vec++; if (bus.cause !== 3'd2) begin n_err++; $display("FAIL halt_cause: got %0d required 2", bus.cause); end
    n_vec++; if (bus.ins_count !== 32'd3) begin n_err++; $display("FAIL halt_count: got %0d required 3", bus.ins_count); end
    n_vec++; if (bus.pc !== 32'd140) begin n_err++; $display("FAIL halt_pc: got %0d required 140", bus.pc); end
    halt_addr = FAR;
  endtask

  task automatic test_breakpoint();
    bus.bp_en = 1'b1;
    bus.bp_addr = 32'd136;
    launch(32'd128);
    run_until_done(20);
    n_vec++; if (bus.cause !== 3'd3) begin n_err++; $display("FAIL bp_cause: got %0d required 3", bus.cause); end
    n_vec++; if (bus.ins_count !== 32'd2) begin n_err++; $display("FAIL bp_count: got %0d required 2", bus.ins_count); end
    n_vec++; if (bus.pc !== 32'd136) begin n_err++; $display("FAIL bp_pc: got %0d required 136", bus.pc); end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n_vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL step_busy: got busy=%0b done=%0b required 1/0", bus.busy, bus.done); end
    tick();
    n_vec++; if (ce_last !== 1'b1) begin n_err++; $display("FAIL step_en: got %0b required 1", ce_last); end
    n_vec++; if (bus.ins_count !== 32'd3) begin n_err++; $display("FAIL step_count: got %0d required 3", bus.ins_count); end
    n_vec++; if (bus.cause !== 3'd0) begin n_err++; $display("FAIL step_cause: got %0d required 0", bus.cause); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL step_done: got %0b required 1", bus.done); end
    n_vec++; if (bus.pc !== 32'd140) begin n_err++; $display("FAIL step_pc: got %0d required 140", bus.pc); end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (bus.ins_count !== 32'd6) begin n_err++; $display("FAIL resume_count: got %0d required 6", bus.ins_count); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL resume_busy: got %0b required 1", bus.busy); end
  endtask

  task automatic test_priority();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    // halt_req while stopped changes nothing
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n_vec++; if (bus.done !== 1'b1 || bus.cause !== 3'd1) begin n_err++; $display("FAIL stopped_halt_req: got done=%0b cause=%0d required 1/1", bus.done, bus.cause); end
    launch(32'd128);
    tick(); tick();
    n_vec++; if (bus.pc !== 32'd136) begin n_err++; $display("FAIL prio_pc: got %0d required 136", bus.pc); end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n_vec++; if (bus.cause !== 3'd1) begin n_err++; $display("FAIL prio_cause: got %0d required 1", bus.cause); end
    n_vec++; if (bus.ins_count !== 32'd2) begin n_err++; $display("FAIL prio_count: got %0d required 2", bus.ins_count); end
    n_vec++; if (ce_last !== 1'b0) begin n_err++; $display("FAIL prio_en: got %0b required 0", ce_last); end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    launch(32'd128);
    tick(); tick();
    #2;
    INT = 1'b1;
    #1;
    n_vec++; if (bus.cpu_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_en: got %0b required 0", bus.cpu_en); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got busy=%0b done=%0b required 0/0", bus.busy, bus.done); end
    n_vec++; if (bus.ins_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d required 0", bus.ins_count); end
    @(posedge clk);
    #1;
    INT = 1'b0;
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL idle_ignore: got busy=%0b done=%0b required 0/0", bus.busy, bus.done); end
    bus.entry_point = 32'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.pc_load !== 1'b1 || bus.pc_entry !== 32'd200) begin n_err++; $display("FAIL relaunch_load: got pc_load=%0b pc_entry=%0d required 1/200", bus.pc_load, bus.pc_entry); end
    tick();
    tick();
    n_vec++; if (bus.ins_count !== 32'd1) begin n_err++; $display("FAIL relaunch_count: got %0d required 1", bus.ins_count); end
    n_vec++; if (bus.pc !== 32'd204) begin n_err++; $display("FAIL relaunch_pc: got %0d required 204", bus.pc); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ce_last = 1'b0;
    halt_addr = FAR;
    INT = 1'b1;
    bus.start = 1'b0;
    bus.resume = 1'b0;
    bus.step = 1'b0;
    bus.halt_req = 1'b0;
    bus.entry_point = 32'd0;
    bus.max_cycles = 32'd0;
    bus.bp_en = 1'b0;
    bus.bp_addr = 32'd0;
    bus.pc = 32'd0;
    bus.ins = NOP;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    INT = 1'b0;
    test_start_count();
    test_budget();
    test_halt_ins();
    test_breakpoint();
    test_priority();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/y_run_ctl.md
Name: y_run_ctl

Overview:
- Run/debug sequencer for the single-cycle CPU datapath (yIF/yID/yEX/yDM/yWB/yPC plus yC1–yC4).
- Loads the entry point, then gates datapath state updates.
- Runs free, single-steps or stops, on four conditions: a halt instruction, a PC breakpoint, a cycle budget or an external request.
- Replaces the fixed-count, hand-pulsed INT sequencing in test benches with a synthesizable controller.

Parameters:
- HALT_INS, 32'h0000000C: instruction word treated as program end.
- CNT_W, 32: width of the instruction counter and budget.

Ports:
- clk  in  1  system clock, rising-edge.
- INT  in  1  asynchronous, active-high reset.
- start  in  1  begin a new run from entry_point.
- resume  in  1  continue from STOPPED.
- step  in  1  execute exactly one instruction from STOPPED.
- halt_req  in  1  external stop request.
- entry_point  in  32  program start address.
- max_cycles  in  CNT_W  instruction budget; 0 means unlimited.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc  in  32  current fetch address (yIF PC register).
- ins  in  32  current fetched instruction.
- pc_load  out  1  drives yPC INT: select entry_point this cycle.
- pc_entry  out  32  address presented to yPC entryPoint.
- cpu_en  out  1  enables PC, register-file and memory writes.
- busy  out  1  high in LOAD/RUN/STEP.
- done  out  1  high in STOPPED.
- cause  out  3  stop cause: 0 none, 1 external, 2 halt instruction, 3 breakpoint, 4 budget.
- ins_count  out  CNT_W  instructions retired this run.

Behaviour:
- Reset (async, INT=1):
  - state = IDLE.
  - pc_load, cpu_en, busy, done = 0.
  - cause = 0, ins_count = 0.
  - pc_entry = 0.
  - Reset mid-run aborts immediately; no further cpu_en.
- States: IDLE, LOAD, RUN, STEP, STOPPED. Encoding is internal.
- IDLE:
  - All enables 0.
  - start=1 → LOAD; latch entry_point into pc_entry.
  - resume and step are ignored.
- LOAD (exactly 1 cycle):
  - pc_load=1, cpu_en=0.
  - ins_count←0, cause←0.
  - Next state is RUN.
- RUN:
  - Each cycle, evaluate the stop conditions on the current pc/ins before executing, in this priority:
    1. halt_req → cause 1.
    2. ins==HALT_INS → cause 2.
    3. bp_en && pc==bp_addr && !bp_skip → cause 3.
    4. max_cycles!=0 && ins_count==max_cycles → cause 4.
  - On any hit: cpu_en=0 that cycle, state → STOPPED, cause latched, the instruction is not executed.
  - Otherwise: cpu_en=1, ins_count+1. ins_count wraps at 2^CNT_W without flagging.
- bp_skip:
  - Set on entry to RUN/STEP from STOPPED when the stop cause was 3.
  - Cleared after the first executed instruction.
  - Effect: resuming at a breakpoint does not re-stop at the same PC.
- STOPPED:
  - done=1; cause held.
  - resume → RUN; cause←0.
  - step → STEP.
  - start → LOAD (new run).
  - Simultaneous inputs: start > resume > step.
  - halt_req while STOPPED has no effect.
- STEP (1 cycle):
  - Apply the RUN stop checks except the budget check.
  - No hit: cpu_en=1, ins_count+1, → STOPPED with cause 0.
  - Hit: cpu_en=0, → STOPPED with the new cause.
- start while busy: ignored, with one exception: start together with halt_req in RUN stops with cause 1 and does not restart.
- All outputs are registered from state except cpu_en.
  - cpu_en is combinational from state, pc and ins, so it is valid in the same cycle.
  - It must be settled before the clk rising edge, matching the single-cycle datapath.

Decomposition:
- Shared package/header `y_defs`:
  - state encodings;
  - cause codes (CAUSE_NONE..CAUSE_BUDGET);
  - HALT_INS default.
- Sub-module `y_stop_chk`: purely combinational priority checker.
  - Inputs: halt_req, ins, pc, bp_en, bp_addr, bp_skip, budget_en, ins_count, max_cycles.
  - Outputs: hit, cause.
  - Reused by RUN and STEP.
- Everything else is inline.

Test Plan:
- Reset then start with entry_point=128 → one cycle of pc_load=1 with pc_entry=128, then cpu_en=1 and ins_count counting 1,2,3…
- Program of 43 non-halt instructions with max_cycles=43 → STOPPED with cause=4 and ins_count=43; cpu_en low on the 44th cycle.
- HALT_INS placed at address 140 → stops with pc=140, cause=2, ins_count=3; no write enable on the halt cycle.
- Breakpoint at pc=136 → stop with cause=3 and ins_count=2. Then step → ins_count=3 with the breakpoint skipped, cause=0. Then resume → runs on.
- halt_req asserted simultaneously with a breakpoint hit → cause=1 (priority).
- INT asserted mid-RUN between edges → outputs 0 and state IDLE immediately; resume then ignored, and start relaunches from entry_point.
